// File: rtl/tx_req_queue.sv
// tx_req_queue: request FIFO feeding the gPTP transmit-timestamp stage.
// Issues one request at a time and waits for its timestamp. Returns the timestamp,
// tagged with the request addr, on a valid/ready result port. A watchdog drops
// requests whose timestamp never comes back.
module tx_req_queue #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned AW      = 3,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_vaild,
  output logic          req_ready,
  input  logic [7:0]    req_addr,
  input  logic [79:0]   req_data,
  output logic [7:0]    send_addr,
  output logic          send_vaild,
  input  logic          send_ready,
  output logic [79:0]   send_data,
  input  logic          send_r_vaild,
  input  logic [79:0]   send_r_data,
  output logic          ts_out_vaild,
  input  logic          ts_out_ready,
  output logic [7:0]    ts_out_addr,
  output logic [79:0]   ts_out_data,
  output logic          ts_timeout,
  output logic [AW:0]   q_level
);

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 80;
  localparam int unsigned LW     = AW + 1;
  localparam int unsigned WD_W   = $clog2(TIMEOUT);

  localparam logic [LW-1:0]   FULL_LVL = LW'(DEPTH);
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_TS = 2'd2
  } state_e;

  // FIFO storage and bookkeeping
  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]     level_q, level_d;
  logic              push, pop;

  // FSM and output registers
  state_e            state_q, state_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              send_vaild_q, send_vaild_d;
  logic [ADDR_W-1:0] send_addr_q, send_addr_d;
  logic [DATA_W-1:0] send_data_q, send_data_d;
  logic              ts_vaild_q, ts_vaild_d;
  logic [ADDR_W-1:0] ts_addr_q, ts_addr_d;
  logic [DATA_W-1:0] ts_data_q, ts_data_d;
  logic              ts_timeout_q, ts_timeout_d;

  assign req_ready = (level_q != FULL_LVL);
  assign push      = req_vaild && req_ready;

  // Occupancy: push and pop in the same cycle leave the level unchanged
  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Entry storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr_q] <= req_addr;
      mem_data[wr_ptr_q] <= req_data;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
    end
  end

  // Next-state, watchdog and output updates
  always_comb begin
    state_d      = state_q;
    wd_d         = wd_q;
    send_vaild_d = send_vaild_q;
    send_addr_d  = send_addr_q;
    send_data_d  = send_data_q;
    ts_vaild_d   = ts_vaild_q;
    ts_addr_d    = ts_addr_q;
    ts_data_d    = ts_data_q;
    ts_timeout_d = 1'b0;
    pop          = 1'b0;

    if (ts_vaild_q && ts_out_ready) ts_vaild_d = 1'b0;

    unique case (state_q)
      // Issue only with a free result slot: the timestamp pulse cannot be stalled
      IDLE: begin
        if ((level_q != '0) && !ts_vaild_q) begin
          pop          = 1'b1;
          send_addr_d  = mem_addr[rd_ptr_q];
          send_data_d  = mem_data[rd_ptr_q];
          send_vaild_d = 1'b1;
          wd_d         = '0;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (send_ready) begin
          send_vaild_d = 1'b0;
          wd_d         = '0;
          state_d      = WAIT_TS;
        end else if (wd_q == WD_LAST) begin
          send_vaild_d = 1'b0;
          ts_timeout_d = 1'b1;
          state_d      = IDLE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      // A returning timestamp takes priority over the terminal count
      WAIT_TS: begin
        if (send_r_vaild) begin
          ts_data_d  = send_r_data;
          ts_addr_d  = send_addr_q;
          ts_vaild_d = 1'b1;
          state_d    = IDLE;
        end else if (wd_q == WD_LAST) begin
          ts_timeout_d = 1'b1;
          send_vaild_d = 1'b0;
          state_d      = IDLE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      wd_q         <= '0;
      send_vaild_q <= 1'b0;
      send_addr_q  <= '0;
      send_data_q  <= '0;
      ts_vaild_q   <= 1'b0;
      ts_addr_q    <= '0;
      ts_data_q    <= '0;
      ts_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wd_q         <= wd_d;
      send_vaild_q <= send_vaild_d;
      send_addr_q  <= send_addr_d;
      send_data_q  <= send_data_d;
      ts_vaild_q   <= ts_vaild_d;
      ts_addr_q    <= ts_addr_d;
      ts_data_q    <= ts_data_d;
      ts_timeout_q <= ts_timeout_d;
    end
  end

  assign send_vaild   = send_vaild_q;
  assign send_addr    = send_addr_q;
  assign send_data    = send_data_q;
  assign ts_out_vaild = ts_vaild_q;
  assign ts_out_addr  = ts_addr_q;
  assign ts_out_data  = ts_data_q;
  assign ts_timeout   = ts_timeout_q;
  assign q_level      = level_q;

endmodule
